bitwise_alu_seq: RTL and testbench

BITWISE_ALU_SEQ -- requirements
Module: bitwise_alu_seq

---
 rtl/bitwise_alu_seq.sv | 132 +++++++++++++
 tb/tb_bitwise_alu_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bitwise_alu_seq.sv
// Sequential bitwise/shift ALU: logic ops finish in one cycle, while shifts and
// rotates step one bit per cycle through a working register.
module bitwise_alu_seq #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] work_reg;
  logic [SHW-1:0]   cnt_reg;
  logic [WIDTH-1:0] y_reg;
  logic             zero_reg;

  logic             is_shift;
  logic             start_shift;
  logic             last_step;
  logic [WIDTH-1:0] imm_result;
  logic [WIDTH-1:0] rol_step;
  logic [WIDTH-1:0] step_result;

  assign is_shift    = op[2] & (op[1] | op[0]);
  assign start_shift = is_shift && (shamt != '0);
  assign last_step   = (cnt_reg == SHW'(1));

  // One-bit left rotate of the working register; bit WIDTH-1 wraps into bit 0.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rol
    assign rol_step[gi] = work_reg[(gi + WIDTH - 1) % WIDTH];
  end

  always_comb begin
    imm_result = '0;
    case (op)
      3'b000:  imm_result = a & b;
      3'b001:  imm_result = a | b;
      3'b010:  imm_result = a ^ b;
      3'b011:  imm_result = ~a;
      3'b100:  imm_result = ~b;
      3'b110:  imm_result = b;
      default: imm_result = a;
    endcase
  end

  always_comb begin
    step_result = '0;
    case (op_reg)
      3'b101:  step_result = work_reg << 1;
      3'b110:  step_result = work_reg >> 1;
      default: step_result = rol_step;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = start_shift ? SHIFT : DONE;
      SHIFT:   if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
    busy      = (state_reg != IDLE);
  end

  // y and zero are written only on completion, so they hold steady through DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_reg   <= '0;
      work_reg <= '0;
      cnt_reg  <= '0;
      y_reg    <= '0;
      zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_reg <= op;
            if (start_shift) begin
              work_reg <= (op == 3'b110) ? b : a;
              cnt_reg  <= shamt;
            end else begin
              y_reg    <= imm_result;
              zero_reg <= (imm_result == '0);
            end
          end
        end
        SHIFT: begin
          work_reg <= step_result;
          cnt_reg  <= cnt_reg - SHW'(1);
          if (last_step) begin
            y_reg    <= step_result;
            zero_reg <= (step_result == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign y    = y_reg;
  assign zero = zero_reg;

endmodule

// File: tb/tb_bitwise_alu_seq.sv
// Directed bench for bitwise_alu_seq at WIDTH=8: logic ops, shift latency,
// rotate wrap, backpressure and reset abort.
module tb_bitwise_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] shamt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       zero;
  logic       busy;

  int total;
  int bad;

  bitwise_alu_seq #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .a(a),
    .b(b),
    .shamt(shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y(y),
    .zero(zero),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got 'h%0h want 'h%0h", tag, obs, exp_v);
    end
  endtask

  // Issue one request, measure latency to out_valid, check result, then drain it.
  task automatic do_req(input string tag, input logic [2:0] t_op, input logic [7:0] t_a,
                        input logic [7:0] t_b, input logic [2:0] t_sh,
                        input logic [7:0] exp_y, input logic exp_z, input int exp_lat);
    int  lat;
    logic busy_ok;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    op = t_op;
    a = t_a;
    b = t_b;
    shamt = t_sh;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, busy_ok & busy, 1'b1);
    check({tag, "_y"}, y, exp_y);
    check({tag, "_zero"}, zero, exp_z);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drain"}, {out_valid, in_ready}, 2'b01);
    $display("txn %s op=%0d a=%h b=%h sh=%0d y=%h zero=%0d lat=%0d", tag, t_op, t_a, t_b, t_sh, y, zero, lat);
  endtask

  initial begin
    logic seen_valid;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b1;
    op = 3'b000;
    a = 8'hFF;
    b = 8'hFF;
    shamt = 3'd0;
    out_ready = 1'b0;

    // Reset with a live request on the inputs: it must be ignored.
    repeat (3) @(negedge clk);
    check("rst_y", y, 8'h00);
    check("rst_flags", {zero, out_valid, busy}, 3'b000);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_no_result", out_valid, 1'b0);
    $display("txn reset y=%h in_ready=%0d", y, in_ready);

    do_req("and",     3'b000, 8'hAA, 8'hCC, 3'd0, 8'h88, 1'b0, 1);
    do_req("not_a",   3'b011, 8'h0F, 8'h00, 3'd0, 8'hF0, 1'b0, 1);
    do_req("xor_z",   3'b010, 8'h5A, 8'h5A, 3'd0, 8'h00, 1'b1, 1);
    do_req("or",      3'b001, 8'hA0, 8'h05, 3'd0, 8'hA5, 1'b0, 1);
    do_req("not_b",   3'b100, 8'h00, 8'h3C, 3'd0, 8'hC3, 1'b0, 1);
    do_req("shl0",    3'b101, 8'h37, 8'h00, 3'd0, 8'h37, 1'b0, 1);
    do_req("shl3",    3'b101, 8'h81, 8'h00, 3'd3, 8'h08, 1'b0, 4);
    do_req("shr7",    3'b110, 8'h00, 8'h80, 3'd7, 8'h01, 1'b0, 8);
    do_req("rol1",    3'b111, 8'h81, 8'h00, 3'd1, 8'h03, 1'b0, 2);
    do_req("rol7",    3'b111, 8'h81, 8'h00, 3'd7, 8'hC0, 1'b0, 8);
    do_req("shl7",    3'b101, 8'hFF, 8'h00, 3'd7, 8'h80, 1'b0, 8);
    do_req("shr_z",   3'b110, 8'h00, 8'h0F, 3'd5, 8'h00, 1'b1, 6);

    // Backpressure: hold the result while a new request waits on the inputs.
    @(negedge clk);
    in_valid = 1'b1;
    op = 3'b000;
    a = 8'hF0;
    b = 8'h3C;
    shamt = 3'd0;
    @(negedge clk);
    op = 3'b001;
    a = 8'h01;
    b = 8'h02;
    check("bp_first", {out_valid, y}, {1'b1, 8'h30});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_y", y, 8'h30);
      check("bp_hold_ctl", {out_valid, in_ready, busy}, 3'b101);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle", {out_valid, in_ready}, 2'b01);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_pending", {out_valid, y}, {1'b1, 8'h03});
    $display("txn backpressure held=30 pending y=%h", y);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset lands on the third SHIFT edge of a 6-step shift.
    in_valid = 1'b1;
    op = 3'b101;
    a = 8'h01;
    shamt = 3'd6;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ab_mid", {busy, y}, {1'b1, 8'h03});
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("ab_y", y, 8'h00);
    check("ab_flags", {zero, out_valid, busy}, 3'b000);
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("ab_no_valid", seen_valid, 1'b0);
    check("ab_in_ready", in_ready, 1'b1);
    $display("txn reset_abort y=%h out_valid_seen=%0d", y, seen_valid);

    do_req("post_ab", 3'b000, 8'h0F, 8'h3C, 3'd0, 8'h0C, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
